// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel conditioner for asynchronous board inputs such as push-buttons,
// switches and external strobes. Each channel has three parts in series:
//   1. a STAGES-deep flip-flop synchroniser,
//   2. a debounce counter that accepts a new level only after it has held
//      for DB_CYCLES consecutive clocks,
//   3. a registered edge detector that gives one-cycle rise/fall pulses.
// Channels share no state.
//
// Parameters
//   WIDTH      number of independent channels (>= 1)
//   STAGES     synchroniser flip-flops per channel (>= 2)
//   DB_CYCLES  consecutive cycles a new level must persist (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   sig_in      raw asynchronous inputs, one bit per channel
//   sig_sync    last synchroniser stage (not debounced)
//   sig_stable  debounced level per channel
//   rise        one-cycle pulse when sig_stable goes 0->1
//   fall        one-cycle pulse when sig_stable goes 1->0
//
// Every output is a flop output, so there is no combinational path from
// sig_in to any output.
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_sync,
  output logic [WIDTH-1:0] sig_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // Counter value at which the next disagreeing edge accepts the new level.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic              stable;
    logic              rise_q;
    logic              fall_q;
    logic              sync;

    // chain[0] samples the pin. The oldest stage is the synchronised level.
    assign sync = chain[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chain  <= '0;
        cnt    <= '0;
        stable <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        chain  <= {chain[STAGES-2:0], sig_in[i]};
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync == stable) begin
          // Agreement at any point clears a partial count (glitch rejection).
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // New level has held long enough: accept it and pulse the edge.
          stable <= sync;
          cnt    <= '0;
          rise_q <= sync;
          fall_q <= ~sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign sig_sync[i]   = sync;
    assign sig_stable[i] = stable;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int W  = 4;
  localparam int ST = 2;
  localparam int DB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] sig_in   = '0;
  logic [W-1:0] sig_in_b = '0;
  logic [W-1:0] sig_sync, sig_stable, rise, fall;
  logic [W-1:0] sig_sync_b, sig_stable_b, rise_b, fall_b;

  input_conditioner #(.WIDTH(W), .STAGES(ST), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .sig_sync(sig_sync), .sig_stable(sig_stable), .rise(rise), .fall(fall)
  );

  // Parameter-sweep instance: STAGES=3, DB_CYCLES=1.
  input_conditioner #(.WIDTH(W), .STAGES(3), .DB_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in_b),
    .sig_sync(sig_sync_b), .sig_stable(sig_stable_b), .rise(rise_b), .fall(fall_b)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // sig_sync is the input sampled STAGES edges ago. A channel's stable level
  // flips when the synchronised level seen at each of the last DB edges
  // differs from it; the flip edge also produces the rise/fall pulse.
  logic [W-1:0] in_q[$];
  logic [W-1:0] exp_q[$];  // synchronised levels seen at recent edges
  logic [W-1:0] m_sync, m_stable, m_rise, m_fall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q.delete();
      exp_q.delete();
      m_sync = '0; m_stable = '0; m_rise = '0; m_fall = '0;
    end else begin
      exp_q.push_back(m_sync);
      if (exp_q.size() > DB) void'(exp_q.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        bit all_differ;
        all_differ = (exp_q.size() == DB);
        foreach (exp_q[j]) if (exp_q[j][i] == m_stable[i]) all_differ = 0;
        if (all_differ) begin
          m_stable[i] = ~m_stable[i];
          m_rise[i]   = m_stable[i];
          m_fall[i]   = ~m_stable[i];
        end
      end
      in_q.push_back(sig_in);
      if (in_q.size() > ST) void'(in_q.pop_front());
      m_sync = (in_q.size() == ST) ? in_q[0] : '0;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sync",   32'(sig_sync),   32'(m_sync));
      check("model_stable", 32'(sig_stable), 32'(m_stable));
      check("model_rise",   32'(rise),       32'(m_rise));
      check("model_fall",   32'(fall),       32'(m_fall));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int pulses;
  int at;

  initial begin
    #12;
    check("reset_sync",   32'(sig_sync),   32'h0);
    check("reset_stable", 32'(sig_stable), 32'h0);
    check("reset_rise",   32'(rise),       32'h0);
    check("reset_fall",   32'(fall),       32'h0);
    check("reset_b",      32'({sig_sync_b, sig_stable_b, rise_b, fall_b}), 32'h0);
    @(negedge clk) rst = 1'b0;
    chk_en = 1;
    wait_edges(3);

    // Clean rise on channel 0.
    @(negedge clk) sig_in = 4'b0001;
    wait_edges(1);
    check("rise_sync_e1", 32'(sig_sync[0]), 32'h0);
    wait_edges(1);
    check("rise_sync_e2", 32'(sig_sync[0]), 32'h1);
    wait_edges(3);
    check("rise_stable_e5", 32'(sig_stable[0]), 32'h0);
    wait_edges(1);
    check("rise_stable_e6", 32'(sig_stable[0]), 32'h1);
    check("rise_pulse_e6",  32'(rise),          32'h1);
    check("rise_others",    32'(sig_stable[3:1]), 32'h0);
    wait_edges(1);
    check("rise_pulse_e7",  32'(rise[0]), 32'h0);

    // Glitch on channel 1: three cycles high, then low.
    @(negedge clk) sig_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    sig_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_edges(1);
      check("glitch_quiet", 32'({sig_stable[1], rise[1], fall[1]}), 32'h0);
    end

    // Bounce burst on channel 2, then hold high.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) sig_in[2] = (k % 2 == 0);
    end
    pulses = 0;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      wait_edges(1);
      if (rise[2]) begin
        pulses++;
        at = k;
      end
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_edge",   32'(at),     32'd6);

    // Channels 0 and 3 stable high, then drop together.
    @(negedge clk) sig_in = 4'b1101;
    wait_edges(10);
    check("fall_pre_stable", 32'(sig_stable), 32'hd);
    @(negedge clk) sig_in = 4'b0100;
    wait_edges(5);
    check("fall_e5", 32'(fall), 32'h0);
    wait_edges(1);
    check("fall_e6", 32'(fall), 32'h9);
    check("fall_e6_rise", 32'(rise), 32'h0);
    wait_edges(1);
    check("fall_e7", 32'(fall), 32'h0);
    check("fall_stable", 32'(sig_stable), 32'h4);

    // Reset in the middle of a count with all inputs high.
    @(negedge clk) sig_in = 4'b1111;
    wait_edges(3);
    check("rst_pre_sync", 32'(sig_sync), 32'hf);
    #1 rst = 1'b1;
    #1;
    check("rst_async_sync",   32'(sig_sync),   32'h0);
    check("rst_async_stable", 32'(sig_stable), 32'h0);
    check("rst_async_pulses", 32'({rise, fall}), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_edges(5);
    check("rst_rel_e5", 32'(sig_stable), 32'h0);
    wait_edges(1);
    check("rst_rel_e6_stable", 32'(sig_stable), 32'hf);
    check("rst_rel_e6_rise",   32'(rise),       32'hf);
    check("rst_rel_e6_fall",   32'(fall),       32'h0);
    wait_edges(1);
    check("rst_rel_e7_rise",   32'(rise),       32'h0);

    // Randomised phase, with one short reset pulse inside a low clock phase.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) sig_in[i] = ~sig_in[i];
      if (c == 300) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    // Parameter sweep: STAGES=3, DB_CYCLES=1 gives rise after 4 edges.
    @(negedge clk) sig_in_b = 4'b0001;
    wait_edges(3);
    check("sweep_e3_rise", 32'(rise_b), 32'h0);
    check("sweep_e3_sync", 32'(sig_sync_b), 32'h1);
    wait_edges(1);
    check("sweep_e4_rise",   32'(rise_b),       32'h1);
    check("sweep_e4_stable", 32'(sig_stable_b), 32'h1);
    wait_edges(1);
    check("sweep_e5_rise", 32'(rise_b), 32'h0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
